// File: rtl/sprite_line_engine.sv
// Per-scanline sprite renderer: walks the attribute table in index order and copies each
// visible sprite row into one bank of a double-buffered line buffer.
module sprite_line_engine #(
   parameter int unsigned       N_SPR        = 64,
   parameter int unsigned       SPR_LOG      = 3,
   parameter int unsigned       MAX_PER_LINE = 16,
   parameter int unsigned       ADDR_W       = 15,
   parameter logic [ADDR_W-1:0] ATTR_BASE    = '0,
   parameter logic [ADDR_W-1:0] PAT_BASE     = 15'h2000,
   parameter int unsigned       X_W          = 9,
   parameter int unsigned       LINE_PIX     = 320,
   parameter logic [7:0]        TRANSP       = 8'h00,
   parameter bit                CLEAR        = 1'b1,
   parameter logic [7:0]        BG_COLOR     = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_start,
   input  logic [7:0]        line_num,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [X_W:0]      lb_addr,
   output logic [7:0]        lb_data,
   output logic              lb_we,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned      SPR_W    = $clog2(N_SPR);
   localparam int unsigned      CNT_W    = $clog2(MAX_PER_LINE + 1);
   localparam logic [SPR_W-1:0] LAST_SPR = SPR_W'(N_SPR - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);
   localparam logic [X_W-1:0]   LAST_X   = X_W'(LINE_PIX - 1);
   localparam logic [X_W:0]     PIX_LIM  = (X_W + 1)'(LINE_PIX);

   typedef enum logic [3:0] {
      StIdle, StClr, StRdY, StRdX, StRdA, StRdI, StChk, StCopy, StDrain, StDone
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         line_q, y_q, xlo_q, id_q;
   logic               xhi_q, hflip_q, vflip_q, ovf_q;
   logic [SPR_W-1:0]   spr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [X_W-1:0]     clr_q;
   logic [SPR_LOG-1:0] col_q;

   logic [7:0]         diff;
   logic               off_row, wr_slot;
   logic [SPR_LOG-1:0] row, colp, pcol;
   logic [X_W-1:0]     px;
   logic [ADDR_W-1:0]  attr_addr;
   state_e             next_spr;

   assign diff      = line_q - y_q;
   assign off_row   = |diff[7:SPR_LOG];
   assign row       = vflip_q ? ~diff[SPR_LOG-1:0] : diff[SPR_LOG-1:0];
   assign colp      = hflip_q ? ~col_q : col_q;
   // Pattern data lags the address by one cycle, so the pixel being written is col_q - 1.
   assign pcol      = col_q - SPR_LOG'(1);
   assign px        = X_W'({xhi_q, xlo_q}) + X_W'(pcol);
   assign wr_slot   = (state_q == StCopy && col_q != '0) || state_q == StDrain;
   assign attr_addr = ATTR_BASE + ADDR_W'({spr_q, 2'b00});
   assign next_spr  = (spr_q == LAST_SPR) ? StDone : StRdY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StIdle;
         StClr:   if (clr_q == LAST_X) state_d = StRdY;
         StRdY:   state_d = StRdX;
         StRdX:   state_d = StRdA;
         StRdA:   state_d = off_row ? next_spr : StRdI;
         StRdI:   state_d = mem_data[3] ? next_spr : StChk;
         StChk:   state_d = (cnt_q == MAX_CNT) ? StDone : StCopy;
         StCopy:  if (col_q == '1) state_d = StDrain;
         StDrain: state_d = next_spr;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // A new line always wins, aborting whatever is in flight.
      if (line_start) state_d = CLEAR ? StClr : StRdY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q  <= '0;
         y_q     <= '0;
         xlo_q   <= '0;
         id_q    <= '0;
         xhi_q   <= 1'b0;
         hflip_q <= 1'b0;
         vflip_q <= 1'b0;
         ovf_q   <= 1'b0;
         spr_q   <= '0;
         cnt_q   <= '0;
         clr_q   <= '0;
         col_q   <= '0;
      end else if (line_start) begin
         line_q <= line_num;
         ovf_q  <= 1'b0;
         spr_q  <= '0;
         cnt_q  <= '0;
         clr_q  <= '0;
         col_q  <= '0;
      end else begin
         case (state_q)
            StClr: clr_q <= clr_q + X_W'(1);
            StRdX: y_q <= mem_data;
            StRdA: begin
               xlo_q <= mem_data;
               if (off_row) spr_q <= spr_q + SPR_W'(1);
            end
            StRdI: begin
               xhi_q   <= mem_data[0];
               hflip_q <= mem_data[1];
               vflip_q <= mem_data[2];
               if (mem_data[3]) spr_q <= spr_q + SPR_W'(1);
            end
            StChk: begin
               id_q <= mem_data;
               if (cnt_q == MAX_CNT) ovf_q <= 1'b1;
               else cnt_q <= cnt_q + CNT_W'(1);
            end
            StCopy:  col_q <= col_q + SPR_LOG'(1);
            StDrain: spr_q <= spr_q + SPR_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_addr = '0;
      mem_rd   = 1'b0;
      lb_addr  = '0;
      lb_data  = '0;
      lb_we    = 1'b0;
      case (state_q)
         StClr: begin
            lb_we   = 1'b1;
            lb_addr = {line_q[0], clr_q};
            lb_data = BG_COLOR;
         end
         StRdY: begin mem_rd = 1'b1; mem_addr = attr_addr; end
         StRdX: begin mem_rd = 1'b1; mem_addr = attr_addr + ADDR_W'(1); end
         StRdA: begin mem_rd = 1'b1; mem_addr = attr_addr + ADDR_W'(2); end
         StRdI: begin mem_rd = 1'b1; mem_addr = attr_addr + ADDR_W'(3); end
         StCopy: begin
            mem_rd   = 1'b1;
            mem_addr = PAT_BASE + ADDR_W'({id_q, row, colp});
         end
         default: ;
      endcase
      if (wr_slot) begin
         lb_addr = {line_q[0], px};
         lb_data = mem_data;
         lb_we   = (mem_data != TRANSP) && ({1'b0, px} < PIX_LIM);
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: one instance without and one with the clear pass,
// sharing a behavioural sprite memory.
module tb_sprite_line_engine;

   localparam int PAT = 'h2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        line_start = 1'b0, line_start_c = 1'b0;
   logic [7:0]  line_num = '0, line_num_c = '0;
   logic [14:0] mem_addr, mem_addr_c;
   logic        mem_rd, mem_rd_c;
   logic [7:0]  mem_data = '0, mem_data_c = '0;
   logic [9:0]  lb_addr, lb_addr_c;
   logic [7:0]  lb_data, lb_data_c;
   logic        lb_we, lb_we_c, busy, busy_c, done, done_c, overflow, overflow_c;

   logic [7:0]  mem [0:32767];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          wr_addr[$];
   int          wr_data[$];
   int          rd_addr[$];
   int          rd_cyc[$];

   always #5 clk = ~clk;

   sprite_line_engine #(.CLEAR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .lb_addr(lb_addr), .lb_data(lb_data), .lb_we(lb_we),
      .busy(busy), .done(done), .overflow(overflow)
   );

   sprite_line_engine #(.CLEAR(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .line_start(line_start_c), .line_num(line_num_c),
      .mem_addr(mem_addr_c), .mem_rd(mem_rd_c), .mem_data(mem_data_c),
      .lb_addr(lb_addr_c), .lb_data(lb_data_c), .lb_we(lb_we_c),
      .busy(busy_c), .done(done_c), .overflow(overflow_c)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd) mem_data <= mem[mem_addr];
      if (mem_rd_c) mem_data_c <= mem[mem_addr_c];
   end

   always @(posedge clk) begin
      if (lb_we) begin
         wr_addr.push_back(int'(lb_addr));
         wr_data.push_back(int'(lb_data));
      end
      if (mem_rd) begin
         rd_addr.push_back(int'(mem_addr));
         rd_cyc.push_back(cyc);
      end
   end

   function automatic logic [7:0] pat_default(input int k);
      return 8'((k % 251) + 1);
   endfunction

   function automatic int find_rd(input int a);
      for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] == a) return rd_cyc[i];
      return -1;
   endfunction

   task automatic set_spr(input int i, input logic [7:0] y, input logic [7:0] xlo,
                          input logic [7:0] a, input logic [7:0] id);
      mem[4*i]   = y;
      mem[4*i+1] = xlo;
      mem[4*i+2] = a;
      mem[4*i+3] = id;
   endtask

   // Y=200 keeps a sprite off every line used here (diff >= 8).
   task automatic clear_attrs();
      for (int i = 0; i < 64; i++) set_spr(i, 8'd200, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic run_line(input logic [7:0] ln, input int max_cyc,
                           output int ndone, output bit timeout);
      @(negedge clk);
      wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rd_cyc.delete();
      line_num = ln;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      ndone = 0;
      timeout = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         if (done) ndone++;
         if (!busy) begin timeout = 1'b0; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({mem_addr, mem_rd, lb_addr, lb_data, lb_we, busy, done, overflow} !== 38'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {mem_addr, mem_rd, lb_addr, lb_data, lb_we, busy, done, overflow});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, mem_rd, lb_we, busy_c, mem_rd_c, lb_we_c} !== 6'd0) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want 000000",
                  {busy, mem_rd, lb_we, busy_c, mem_rd_c, lb_we_c});
      end
   endtask

   task automatic test_basic();
      int nd, c0, c4, np;
      bit to;
      clear_attrs();
      set_spr(0, 8'd10, 8'd20, 8'd0, 8'd5);
      for (int k = 0; k < 8; k++) mem[PAT+336+k] = 8'(k + 1);
      run_line(8'd12, 2000, nd, to);
      total++;
      if (to) begin bad++; $display("FAIL basic_timeout: got busy want idle"); end
      total++;
      if (nd != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", nd); end
      total++;
      if (wr_addr.size() != 8) begin
         bad++; $display("FAIL basic_wr_count: got %0d want 8", wr_addr.size());
      end
      for (int k = 0; k < 8 && k < wr_addr.size(); k++) begin
         total++;
         if (wr_addr[k] != 20 + k || wr_data[k] != k + 1) begin
            bad++;
            $display("FAIL basic_px%0d: got a=%0d d=%0d want a=%0d d=%0d",
                     k, wr_addr[k], wr_data[k], 20 + k, k + 1);
         end
      end
      np = 0;
      for (int i = 0; i < rd_addr.size(); i++) begin
         if (rd_addr[i] >= PAT) begin
            total++;
            if (rd_addr[i] != PAT + 336 + np) begin
               bad++;
               $display("FAIL basic_pat_rd%0d: got %h want %h", np, rd_addr[i], PAT + 336 + np);
            end
            np++;
         end
      end
      total++;
      if (np != 8) begin bad++; $display("FAIL basic_pat_count: got %0d want 8", np); end
      c0 = find_rd(0);
      c4 = find_rd(4);
      total++;
      if (c0 < 0 || c4 - c0 != 14) begin
         bad++; $display("FAIL basic_cost: got %0d want 14", c4 - c0);
      end
   endtask

   task automatic test_attr();
      int ex_x[8][8];
      int ex_d[8][8];
      int yv[8], xl[8], av[8], zo[8], nn[8], co[8];
      int nd, c0, c4;
      bit to;
      yv = '{10, 10, 10, 10, 10, 10, 4, 5};
      xl = '{20, 20, 20, 60, 254, 20, 20, 20};
      av = '{2, 4, 6, 1, 1, 8, 0, 0};
      zo = '{340, -1, -1, -1, -1, -1, -1, -1};
      nn = '{7, 8, 8, 4, 6, 0, 0, 8};
      co = '{14, 14, 14, 14, 14, 4, 3, 14};
      ex_x = '{'{20, 21, 22, 24, 25, 26, 27, 0},  '{20, 21, 22, 23, 24, 25, 26, 27},
               '{20, 21, 22, 23, 24, 25, 26, 27}, '{316, 317, 318, 319, 0, 0, 0, 0},
               '{0, 1, 2, 3, 4, 5, 0, 0},          '{0, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 0, 0, 0, 0},          '{20, 21, 22, 23, 24, 25, 26, 27}};
      ex_d = '{'{8, 7, 6, 4, 3, 2, 1, 0},         '{17, 18, 19, 20, 21, 22, 23, 24},
               '{24, 23, 22, 21, 20, 19, 18, 17}, '{1, 2, 3, 4, 0, 0, 0, 0},
               '{3, 4, 5, 6, 7, 8, 0, 0},         '{0, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 0, 0, 0, 0},         '{126, 127, 128, 129, 130, 131, 132, 133}};
      // Row 5 of pattern 5 feeds the vflip cases (line 12, Y=10 -> diff 2 -> row 5).
      for (int k = 0; k < 8; k++) mem[PAT+360+k] = 8'(17 + k);
      for (int i = 0; i < 8; i++) begin
         clear_attrs();
         set_spr(0, 8'(yv[i]), 8'(xl[i]), 8'(av[i]), 8'd5);
         for (int k = 0; k < 8; k++) mem[PAT+336+k] = 8'(k + 1);
         if (zo[i] >= 0) mem[PAT+zo[i]] = 8'd0;
         run_line(8'd12, 2000, nd, to);
         total++;
         if (to || nd != 1) begin
            bad++; $display("FAIL attr%0d_done: got to=%0d done=%0d want 0/1", i, to, nd);
         end
         total++;
         if (wr_addr.size() != nn[i]) begin
            bad++;
            $display("FAIL attr%0d_wr_count: got %0d want %0d", i, wr_addr.size(), nn[i]);
         end
         for (int k = 0; k < nn[i] && k < wr_addr.size(); k++) begin
            total++;
            if (wr_addr[k] != ex_x[i][k] || wr_data[k] != ex_d[i][k]) begin
               bad++;
               $display("FAIL attr%0d_px%0d: got a=%0d d=%0d want a=%0d d=%0d", i, k,
                        wr_addr[k], wr_data[k], ex_x[i][k], ex_d[i][k]);
            end
         end
         c0 = find_rd(0);
         c4 = find_rd(4);
         total++;
         if (c0 < 0 || c4 - c0 != co[i]) begin
            bad++; $display("FAIL attr%0d_cost: got %0d want %0d", i, c4 - c0, co[i]);
         end
      end
      for (int k = 0; k < 8; k++) mem[PAT+336+k] = 8'(k + 1);
   endtask

   task automatic test_overflow();
      int nd, np, n16;
      bit to;
      clear_attrs();
      for (int i = 0; i <= 16; i++) set_spr(i, 8'd40, 8'd0, 8'd0, 8'(i));
      run_line(8'd40, 3000, nd, to);
      total++;
      if (to || nd != 1) begin
         bad++; $display("FAIL ovf_done: got to=%0d done=%0d want 0/1", to, nd);
      end
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      np = 0;
      n16 = 0;
      foreach (rd_addr[i]) begin
         if (rd_addr[i] >= PAT) np++;
         if (rd_addr[i] >= PAT + 1024 && rd_addr[i] < PAT + 1032) n16++;
      end
      total++;
      if (np != 128) begin bad++; $display("FAIL ovf_pat_reads: got %0d want 128", np); end
      total++;
      if (n16 != 0) begin bad++; $display("FAIL ovf_spr16_read: got %0d want 0", n16); end
      total++;
      if (wr_addr.size() != 128) begin
         bad++; $display("FAIL ovf_wr_count: got %0d want 128", wr_addr.size());
      end
      // Sprite 15 is the last drawn: pattern 15 row 0 sits at offset 960.
      for (int k = 0; k < 8 && 120 + k < wr_addr.size(); k++) begin
         total++;
         if (wr_addr[120+k] != k || wr_data[120+k] != 208 + k) begin
            bad++;
            $display("FAIL ovf_last_px%0d: got a=%0d d=%0d want a=%0d d=%0d", k,
                     wr_addr[120+k], wr_data[120+k], k, 208 + k);
         end
      end
      repeat (4) @(negedge clk);
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_abort();
      bit seen;
      int nd;
      clear_attrs();
      set_spr(0, 8'd6, 8'd20, 8'd0, 8'd5);
      @(negedge clk);
      line_num = 8'd6;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (lb_we) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!seen) begin bad++; $display("FAIL abort_copy_reached: got 0 want 1"); end
      line_num = 8'd7;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      wr_addr.delete(); wr_data.delete();
      total++;
      if ({lb_we, overflow, busy} !== 3'b001) begin
         bad++; $display("FAIL abort_next_cycle: got we/ovf/busy=%b want 001", {lb_we, overflow, busy});
      end
      nd = 0;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done) nd++;
         if (!busy) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!seen || nd != 1) begin
         bad++; $display("FAIL abort_done: got idle=%0d done=%0d want 1/1", seen, nd);
      end
      total++;
      if (wr_addr.size() != 8) begin
         bad++; $display("FAIL abort_wr_count: got %0d want 8", wr_addr.size());
      end
      // Line 7, Y=6 -> row 1 of pattern 5 (offset 328), bank 1.
      for (int k = 0; k < 8 && k < wr_addr.size(); k++) begin
         total++;
         if (wr_addr[k] != 512 + 20 + k || wr_data[k] != 78 + k) begin
            bad++;
            $display("FAIL abort_px%0d: got a=%0d d=%0d want a=%0d d=%0d", k,
                     wr_addr[k], wr_data[k], 532 + k, 78 + k);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int k, good, nd;
      clear_attrs();
      set_spr(0, 8'd10, 8'd20, 8'd0, 8'd5);
      @(negedge clk);
      line_num_c = 8'd12;
      line_start_c = 1'b1;
      @(negedge clk);
      line_start_c = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (mem_rd_c && int'(mem_addr_c) >= PAT) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_copy_reached: got 0 want 1"); end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({mem_addr_c, mem_rd_c, lb_addr_c, lb_data_c, lb_we_c, busy_c, done_c, overflow_c}
          !== 38'd0) begin
         bad++;
         $display("FAIL rstmid_outputs: got %h want 0", {mem_addr_c, mem_rd_c, lb_addr_c,
                  lb_data_c, lb_we_c, busy_c, done_c, overflow_c});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (busy_c !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", busy_c); end
      line_start_c = 1'b1;
      @(negedge clk);
      line_start_c = 1'b0;
      k = 0;
      good = 0;
      while (k < 400 && !mem_rd_c) begin
         if (lb_we_c && lb_data_c == 8'h00 && lb_addr_c == 10'(k)) good++;
         k++;
         @(negedge clk);
      end
      total++;
      if (k != 320) begin bad++; $display("FAIL clr_cycles: got %0d want 320", k); end
      total++;
      if (good != 320) begin bad++; $display("FAIL clr_writes: got %0d want 320", good); end
      total++;
      if (mem_addr_c !== 15'd0) begin
         bad++; $display("FAIL clr_first_rd: got %h want 0", mem_addr_c);
      end
      nd = 0;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done_c) nd++;
         if (!busy_c) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!seen || nd != 1) begin
         bad++; $display("FAIL clr_line_done: got idle=%0d done=%0d want 1/1", seen, nd);
      end
   endtask

   initial begin
      for (int k = 0; k < 16384; k++) mem[PAT+k] = pat_default(k);
      clear_attrs();
      test_reset();
      test_basic();
      test_attr();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
